jb_rr_select_8: RTL and testbench

Eight-requester round-robin arbiter that produces the 3-bit select index consumed by the 3-to-8 active-low chip-select decoder in the regmap slave path. It sits directly upstream of that decoder. It grants one requester at a time, holds the grant until the transaction ends, and inserts programmable dead time between grants. sel_valid qualifies sel, because the decoder always drives one line low; downstream logic gates the decoded enables with sel_valid.

---
 rtl/jb_rr_select_8.sv | 130 +++++++++++++
 tb/tb_jb_rr_select_8.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/jb_rr_select_8.sv
// Eight-way round-robin arbiter producing a registered 3-bit select index with
// hold-time timeout and programmable dead time between grants.
module jb_rr_select_8 #(
    parameter int HOLD_MAX   = 255,
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX  == 0) ? 0 : HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] gap_q, gap_d;

    logic [2:0] win;
    logic       found;
    logic [2:0] idx;
    logic       rel_user;
    logic       rel_to;

    // Scan from the farthest offset down so the bit nearest ptr wins last.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr_q + 3'(k);
            if (req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign rel_user = done || !req[sel_q];
    assign rel_to   = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d       = win;
                    sel_valid_d = 1'b1;
                    hold_d      = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (rel_user || rel_to) begin
                    sel_valid_d = 1'b0;
                    ptr_d       = sel_q + 3'd1;
                    // A user release coinciding with the limit is not a timeout.
                    timeout_d   = !rel_user;
                    gap_d       = '0;
                    state_d     = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                sel_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 3'd0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= 3'd0;
            hold_q      <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gap_q       <= gap_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_jb_rr_select_8.sv
// Directed bench for jb_rr_select_8: one instance with a short hold limit and
// one-cycle gap, one with no gap.
module tb_jb_rr_select_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;

    logic [2:0] sel_a, sel_b;
    logic       sv_a, sv_b, busy_a, busy_b, to_a, to_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jb_rr_select_8 #(.HOLD_MAX(5), .CNT_W(8), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .sel(sel_a), .sel_valid(sv_a), .busy(busy_a), .timeout(to_a)
    );

    jb_rr_select_8 #(.HOLD_MAX(255), .CNT_W(8), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .sel(sel_b), .sel_valid(sv_b), .busy(busy_b), .timeout(to_b)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [2:0] order_ff [0:8];
    logic [2:0] order_81 [0:3];

    initial begin
        for (int i = 0; i < 8; i++) order_ff[i] = 3'(i);
        order_ff[8] = 3'd0;
        order_81[0] = 3'd0; order_81[1] = 3'd7; order_81[2] = 3'd0; order_81[3] = 3'd7;

        // Reset state and single request
        do_reset();
        check_eq("rst_sel", {5'd0, sel_a}, 8'd0);
        check_eq("rst_sv", {7'd0, sv_a}, 8'd0);
        check_eq("rst_busy", {7'd0, busy_a}, 8'd0);
        check_eq("rst_to", {7'd0, to_a}, 8'd0);
        req = 8'b0000_0100;
        tick();
        check_eq("t1_sel", {5'd0, sel_a}, 8'd2);
        check_eq("t1_sv", {7'd0, sv_a}, 8'd1);
        check_eq("t1_busy", {7'd0, busy_a}, 8'd1);
        req = 8'h00;
        tick();
        check_eq("t1_rel_sv", {7'd0, sv_a}, 8'd0);
        check_eq("t1_gap_busy", {7'd0, busy_a}, 8'd1);
        tick();
        check_eq("t1_idle_busy", {7'd0, busy_a}, 8'd0);
        check_eq("t1_idle_sel", {5'd0, sel_a}, 8'd2);

        // All requesting, done every 4th grant cycle
        do_reset();
        req = 8'hFF;
        tick();
        for (int g = 0; g < 9; g++) begin
            check_eq($sformatf("rr_sel%0d", g), {5'd0, sel_a}, {5'd0, order_ff[g]});
            check_eq($sformatf("rr_sv%0d", g), {7'd0, sv_a}, 8'd1);
            tick(); tick(); tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            check_eq($sformatf("rr_rel%0d", g), {7'd0, sv_a}, 8'd0);
            check_eq($sformatf("rr_to%0d", g), {7'd0, to_a}, 8'd0);
            tick();
            tick();
        end
        req = 8'h00;
        tick(); tick(); tick(); tick();

        // Timeout after HOLD_MAX cycles
        do_reset();
        req = 8'h01;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("to_hold%0d", i), {7'd0, sv_a}, 8'd1);
            tick();
        end
        check_eq("to_rel_sv", {7'd0, sv_a}, 8'd0);
        check_eq("to_pulse", {7'd0, to_a}, 8'd1);
        tick();
        check_eq("to_pulse_end", {7'd0, to_a}, 8'd0);
        tick();
        check_eq("to_regrant_sv", {7'd0, sv_a}, 8'd1);
        check_eq("to_regrant_sel", {5'd0, sel_a}, 8'd0);
        req = 8'h00;
        tick(); tick(); tick();

        // done coinciding with the hold limit is not a timeout
        do_reset();
        req = 8'h08;
        tick();
        check_eq("co_sel", {5'd0, sel_a}, 8'd3);
        tick(); tick(); tick(); tick();
        done = 1'b1;
        req = 8'hFF;
        tick();
        done = 1'b0;
        check_eq("co_rel_sv", {7'd0, sv_a}, 8'd0);
        check_eq("co_to", {7'd0, to_a}, 8'd0);
        tick();
        tick();
        check_eq("co_next_sel", {5'd0, sel_a}, 8'd4);
        req = 8'h00;
        tick(); tick(); tick();

        // Asynchronous reset mid-grant
        do_reset();
        req = 8'h40;
        tick();
        check_eq("ar_sel", {5'd0, sel_a}, 8'd6);
        check_eq("ar_sv", {7'd0, sv_a}, 8'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_sel0", {5'd0, sel_a}, 8'd0);
        check_eq("ar_sv0", {7'd0, sv_a}, 8'd0);
        check_eq("ar_busy0", {7'd0, busy_a}, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("ar_regrant_sel", {5'd0, sel_a}, 8'd6);
        check_eq("ar_regrant_sv", {7'd0, sv_a}, 8'd1);
        req = 8'h00;
        tick(); tick(); tick();

        // Zero-gap instance alternates between two requesters
        do_reset();
        req = 8'h81;
        tick();
        check_eq("ng_sel0", {5'd0, sel_b}, {5'd0, order_81[0]});
        for (int k = 1; k < 4; k++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            check_eq($sformatf("ng_low%0d", k), {7'd0, sv_b}, 8'd0);
            check_eq($sformatf("ng_idle%0d", k), {7'd0, busy_b}, 8'd0);
            tick();
            check_eq($sformatf("ng_sv%0d", k), {7'd0, sv_b}, 8'd1);
            check_eq($sformatf("ng_sel%0d", k), {5'd0, sel_b}, {5'd0, order_81[k]});
        end
        req = 8'h00;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
